// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
//
// Shares the single RTC external-bus cycle engine between three requesters:
// initialization (0), user write control (1) and periodic read sweep (2).
// One command is latched in IDLE, issued to the engine with a one-cycle start
// pulse, and then awaited until the engine reports completion or the wait
// counter expires. The winning requester gets a one-cycle done pulse, and read
// data is returned on rdata.
//
// Ports
//   clk, reset        system clock; asynchronous active-high reset
//   req[2:0]          per-requester request (0 init, 1 user, 2 sweep)
//   wr[2:0]           per-requester command type, 1 = write
//   addr_in[23:0]     per-requester address, byte i belongs to requester i
//   wdata_in[23:0]    per-requester write data, same packing
//   clr_err           synchronous clear of timeout_err
//   gnt[2:0]          one-hot grant, held for the whole transaction
//   done[2:0]         one-cycle completion pulse to the granted requester
//   rdata[7:0]        read result, held until the next completion
//   busy              high in every state except IDLE
//   timeout_err       sticky flag, set when a transaction times out
//   bus_iniciar       one-cycle start pulse to the engine
//   bus_escribe       engine cycle type, 1 = write
//   bus_dir, bus_dato address and write data to the engine
//   bus_final         engine completion pulse
//   bus_rdata         engine read data, valid with bus_final

module rtc_bus_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [2:0]  wr,
   input  logic [23:0] addr_in,
   input  logic [23:0] wdata_in,
   input  logic        clr_err,
   output logic [2:0]  gnt,
   output logic [2:0]  done,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        timeout_err,
   output logic        bus_iniciar,
   output logic        bus_escribe,
   output logic [7:0]  bus_dir,
   output logic [7:0]  bus_dato,
   input  logic        bus_final,
   input  logic [7:0]  bus_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [2:0]  gnt_q, gnt_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        escribe_q, escribe_d;
   logic [7:0]  dir_q, dir_d;
   logic [7:0]  dato_q, dato_d;
   logic [7:0]  cnt_q, cnt_d;
   // 1 = sweep was the last of user/sweep to be served, so user wins the next
   // tie. Init wins never touch it.
   logic        last_sweep_q, last_sweep_d;

   logic [1:0]  sel;
   logic        timeout_hit;

   // Winner index: init has absolute priority, user/sweep alternate on a tie.
   always_comb begin
      sel = 2'd0;
      if (req[0])                sel = 2'd0;
      else if (req[1] && req[2]) sel = last_sweep_q ? 2'd1 : 2'd2;
      else if (req[1])           sel = 2'd1;
      else if (req[2])           sel = 2'd2;
   end

   // NOTE: every signal gets its hold value first so no path leaves one
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      rdata_d      = rdata_q;
      escribe_d    = escribe_q;
      dir_d        = dir_q;
      dato_d       = dato_q;
      cnt_d        = cnt_q;
      last_sweep_d = last_sweep_q;
      timeout_hit  = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d     = 3'(1 << sel);
               escribe_d = wr[sel];
               dir_d     = addr_in[{sel, 3'b000} +: 8];
               dato_d    = wdata_in[{sel, 3'b000} +: 8];
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = 8'd0;
            state_d = WAIT;
         end
         WAIT: begin
            // Completion is checked before the timeout so a bus_final landing
            // on the last wait cycle still counts as success.
            if (bus_final) begin
               if (!escribe_q) rdata_d = bus_rdata;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               timeout_hit = 1'b1;
               rdata_d     = 8'hFF;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            if (gnt_q[1])      last_sweep_d = 1'b0;
            else if (gnt_q[2]) last_sweep_d = 1'b1;
            gnt_d   = 3'b000;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A timeout in the same cycle as clr_err keeps the flag set.
      err_d = timeout_hit | (err_q & ~clr_err);
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         gnt_q        <= 3'b000;
         rdata_q      <= 8'h00;
         err_q        <= 1'b0;
         escribe_q    <= 1'b0;
         dir_q        <= 8'h00;
         dato_q       <= 8'h00;
         cnt_q        <= 8'h00;
         last_sweep_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         escribe_q    <= escribe_d;
         dir_q        <= dir_d;
         dato_q       <= dato_d;
         cnt_q        <= cnt_d;
         last_sweep_q <= last_sweep_d;
      end
   end

   assign gnt         = gnt_q;
   assign done        = (state_q == DONE) ? gnt_q : 3'b000;
   assign rdata       = rdata_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = err_q;
   assign bus_iniciar = (state_q == ISSUE);
   assign bus_escribe = escribe_q;
   assign bus_dir     = dir_q;
   assign bus_dato    = dato_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter
//
// Directed bench for rtc_bus_arbiter with a transaction-level model and a
// small bus-engine responder that answers each start pulse after a chosen
// number of cycles (0 = never answers).

module tb_rtc_bus_arbiter;

   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  req;
   logic [2:0]  wr;
   logic [23:0] addr_in;
   logic [23:0] wdata_in;
   logic        clr_err;
   logic [2:0]  gnt;
   logic [2:0]  done;
   logic [7:0]  rdata;
   logic        busy;
   logic        timeout_err;
   logic        bus_iniciar;
   logic        bus_escribe;
   logic [7:0]  bus_dir;
   logic [7:0]  bus_dato;
   logic        bus_final;
   logic [7:0]  bus_rdata;

   int          n_vec = 0;
   int          n_err = 0;

   int          eng_delay = 0;
   logic [7:0]  eng_data = 8'h00;
   int          eng_cnt = 0;

   rtc_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .addr_in(addr_in),
      .wdata_in(wdata_in), .clr_err(clr_err), .gnt(gnt), .done(done),
      .rdata(rdata), .busy(busy), .timeout_err(timeout_err),
      .bus_iniciar(bus_iniciar), .bus_escribe(bus_escribe), .bus_dir(bus_dir),
      .bus_dato(bus_dato), .bus_final(bus_final), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // A transaction is "active" from grant until the cycle after its done.
   // age 1 is the start-pulse cycle, age k>=2 is the (k-1)th waiting cycle.
   typedef struct {
      bit       active;
      bit       fin;
      int       win;
      int       age;
      bit       wr;
      bit [7:0] dir;
      bit [7:0] dato;
      bit [7:0] rdata;
      bit       err;
      bit       last_sweep;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r = '{default: 0};
      r.last_sweep = 1'b1;
      return r;
   endfunction

   function automatic model_t model_step(model_t c, logic [2:0] rq, logic [2:0] w,
                                         logic [23:0] a, logic [23:0] d,
                                         logic bf, logic [7:0] brd, logic clr);
      model_t n = c;
      bit     set = 1'b0;
      if (!c.active) begin
         if (rq != 3'b000) begin
            if (rq[0])                n.win = 0;
            else if (rq[1] && rq[2])  n.win = c.last_sweep ? 1 : 2;
            else                      n.win = rq[1] ? 1 : 2;
            n.active = 1'b1;
            n.fin    = 1'b0;
            n.age    = 1;
            n.wr     = w[n.win];
            n.dir    = a[8*n.win +: 8];
            n.dato   = d[8*n.win +: 8];
         end
      end else if (c.fin) begin
         n.active = 1'b0;
         n.fin    = 1'b0;
         if (c.win == 1) n.last_sweep = 1'b0;
         if (c.win == 2) n.last_sweep = 1'b1;
      end else begin
         if (c.age >= 2) begin
            if (bf) begin
               n.fin = 1'b1;
               if (!c.wr) n.rdata = brd;
            end else if (c.age - 1 == TIMEOUT) begin
               n.fin   = 1'b1;
               set     = 1'b1;
               n.rdata = 8'hFF;
            end
         end
         n.age = c.age + 1;
      end
      n.err = set ? 1'b1 : (clr ? 1'b0 : c.err);
      return n;
   endfunction

   function automatic logic [2:0] model_gnt(model_t x);
      return x.active ? 3'(1 << x.win) : 3'b000;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m <= model_reset();
      else       m <= model_step(m, req, wr, addr_in, wdata_in, bus_final, bus_rdata, clr_err);
   end

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin
      check("gnt",         32'(gnt),         32'(model_gnt(m)));
      check("done",        32'(done),        32'((m.active && m.fin) ? model_gnt(m) : 3'b000));
      check("busy",        32'(busy),        32'(m.active));
      check("bus_iniciar", 32'(bus_iniciar), 32'(m.active && !m.fin && m.age == 1));
      check("timeout_err", 32'(timeout_err), 32'(m.err));
      check("rdata",       32'(rdata),       32'(m.rdata));
      if (m.active) begin
         check("bus_escribe", 32'(bus_escribe), 32'(m.wr));
         check("bus_dir",     32'(bus_dir),     32'(m.dir));
         check("bus_dato",    32'(bus_dato),    32'(m.dato));
      end
   end

   // ---------------- bus engine responder ----------------
   initial begin
      bus_final = 1'b0;
      bus_rdata = 8'h00;
      forever begin
         @(negedge clk);
         bus_final = 1'b0;
         if (reset) begin
            eng_cnt = 0;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               bus_final = 1'b1;
               bus_rdata = eng_data;
            end
         end else if (bus_iniciar && eng_delay > 0) begin
            eng_cnt = eng_delay;
         end
      end
   end

   // ---------------- bounded waits ----------------
   task automatic wait_iniciar(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus_iniciar) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_iniciar: no start pulse within 40 cycles");
      end
   endtask

   // Returns the done vector and the number of cycles since the call.
   task automatic wait_done(output logic [2:0] g, output int cycles);
      g = 3'b000;
      cycles = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done != 3'b000) begin
            g = done;
            cycles = i;
            break;
         end
      end
      if (cycles == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_done: no done pulse within 40 cycles");
      end
   endtask

   // ---------------- directed stimulus ----------------
   logic [2:0] rr_exp [4] = '{3'b010, 3'b100, 3'b010, 3'b100};

   initial begin
      logic [2:0] g;
      int         c;
      bit         ok;

      req = 3'b000; wr = 3'b000; addr_in = 24'h0; wdata_in = 24'h0; clr_err = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_gnt",   32'(gnt),     32'h0);
      check("rst_busy",  32'(busy),    32'h0);
      check("rst_rdata", 32'(rdata),   32'h0);
      check("rst_dir",   32'(bus_dir), 32'h0);
      reset = 1'b0;

      // Priority: init wins while held, then user/sweep alternate, user first.
      eng_delay = 1; eng_data = 8'h11;
      req = 3'b111; wr = 3'b000; addr_in = 24'h332211; wdata_in = 24'h0;
      for (int i = 0; i < 3; i++) begin
         wait_done(g, c);
         check("prio_init", 32'(g), 32'h1);
      end
      req = 3'b110;
      for (int i = 0; i < 4; i++) begin
         wait_done(g, c);
         check("prio_rr", 32'(g), 32'(rr_exp[i]));
      end
      req = 3'b000;
      check("prio_rdata", 32'(rdata), 32'h11);

      // Single user write, engine answers 3 cycles after the start pulse.
      eng_delay = 3;
      req = 3'b010; wr = 3'b010; addr_in = 24'h002100; wdata_in = 24'h004500;
      wait_iniciar(ok);
      req = 3'b000;
      check("wr_gnt",     32'(gnt),         32'h2);
      check("wr_dir",     32'(bus_dir),     32'h21);
      check("wr_dato",    32'(bus_dato),    32'h45);
      check("wr_escribe", 32'(bus_escribe), 32'h1);
      wait_done(g, c);
      check("wr_done",    32'(g),     32'h2);
      check("wr_latency", 32'(c),     32'd4);
      check("wr_rdata",   32'(rdata), 32'h11);

      // Sweep read returns engine data.
      eng_delay = 2; eng_data = 8'h59;
      req = 3'b100; wr = 3'b000; addr_in = 24'h230000; wdata_in = 24'h0;
      wait_iniciar(ok);
      req = 3'b000;
      check("rd_dir",     32'(bus_dir),     32'h23);
      check("rd_escribe", 32'(bus_escribe), 32'h0);
      wait_done(g, c);
      check("rd_done",  32'(g),     32'h4);
      check("rd_rdata", 32'(rdata), 32'h59);

      // Timeout: engine never answers.
      eng_delay = 0;
      req = 3'b010; wr = 3'b000; addr_in = 24'h004200;
      wait_iniciar(ok);
      req = 3'b000;
      wait_done(g, c);
      check("to_latency", 32'(c),           32'd9);
      check("to_rdata",   32'(rdata),       32'hFF);
      check("to_err",     32'(timeout_err), 32'h1);
      @(negedge clk);
      check("to_sticky",  32'(timeout_err), 32'h1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("to_clr",     32'(timeout_err), 32'h0);

      // Race: bus_final on the last wait cycle wins over the timeout.
      eng_delay = TIMEOUT; eng_data = 8'h3C;
      req = 3'b100; wr = 3'b000; addr_in = 24'h240000;
      wait_iniciar(ok);
      req = 3'b000;
      wait_done(g, c);
      check("race_latency", 32'(c),           32'd9);
      check("race_rdata",   32'(rdata),       32'h3C);
      check("race_err",     32'(timeout_err), 32'h0);

      // Asynchronous reset in the middle of WAIT; req[1] stays pending.
      eng_delay = 0;
      req = 3'b010; wr = 3'b010; addr_in = 24'h005A00; wdata_in = 24'h00A500;
      wait_iniciar(ok);
      repeat (2) @(negedge clk);
      check("mid_busy", 32'(busy), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("ar_gnt",     32'(gnt),         32'h0);
      check("ar_busy",    32'(busy),        32'h0);
      check("ar_done",    32'(done),        32'h0);
      check("ar_iniciar", 32'(bus_iniciar), 32'h0);
      check("ar_escribe", 32'(bus_escribe), 32'h0);
      check("ar_dir",     32'(bus_dir),     32'h0);
      check("ar_dato",    32'(bus_dato),    32'h0);
      repeat (2) @(negedge clk);
      eng_delay = 2; eng_data = 8'h00;
      reset = 1'b0;
      wait_iniciar(ok);
      req = 3'b000;
      check("post_gnt", 32'(gnt),     32'h2);
      check("post_dir", 32'(bus_dir), 32'h5A);
      wait_done(g, c);
      check("post_done", 32'(g), 32'h2);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
